// File: rtl/seq_shift_add_multiplier_if.sv
// Start/done handshake and operand/product bus for seq_shift_add_multiplier.
interface seq_shift_add_multiplier_if #(
    parameter int WA = 3,
    parameter int WB = 4
);
    logic                 start;
    logic [WA-1:0]        A;
    logic [WB-1:0]        B;
    logic                 busy;
    logic                 done;
    logic [WA+WB-1:0]     out;

    modport master (
        output start, A, B,
        input  busy, done, out
    );

    modport slave (
        input  start, A, B,
        output busy, done, out
    );
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-add unsigned multiplier (out = B * A), one multiplier bit per clock.
// Optional macro MULT_EARLY_TERM_EN ends the run once the remaining multiplier bits are zero.
module seq_shift_add_multiplier #(
    parameter int WA = 3,
    parameter int WB = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    seq_shift_add_multiplier_if.slave bus
);
    localparam int W  = WA + WB;
    localparam int CW = (WA > 1) ? $clog2(WA) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [WA-1:0]   a_sh_q, a_sh_d;
    logic [W-1:0]    b_sh_q, b_sh_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [W-1:0]    out_q, out_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    acc_next;
    logic            last_step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        acc_next = acc_q + (a_sh_q[0] ? b_sh_q : '0);
`ifdef MULT_EARLY_TERM_EN
        // No set bits left above the current one: further steps would add nothing.
        last_step = ((a_sh_q >> 1) == '0);
`else
        last_step = (cnt_q == CW'(WA - 1));
`endif

        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        acc_d   = acc_q;
        out_d   = out_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_sh_d  = bus.A;
                    b_sh_d  = W'(bus.B);
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d  = acc_next;
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q << 1;
                cnt_d  = cnt_q + CW'(1);
                if (last_step) begin
                    out_d   = acc_next;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state_q != IDLE);
        bus.done = (state_q == DONE);
        bus.out  = out_q;
    end
endmodule
